pe_group: RTL and testbench
===========================

PE_GROUP -- requirements
Module: pe_group

Interface
REQ-001 SHALL have parameter SHIFT, default 7: arithmetic right-shift applied to each raw row sum before saturation.
REQ-002 SHALL have parameter KSIZE, default 5: kernel width/height; only 5 is supported.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port wgt_load  in  1  strobe; accepts one weight byte per cycle.
REQ-006 SHALL have port wgt_in  in  8  signed weight; 25 bytes row-major, w[r][c] at index 5r+c.
REQ-007 SHALL have port pix_valid  in  1  strobe; accepts one pixel column per cycle.
REQ-008 SHALL have port pix_col  in  40  five signed pixels; row r in bits [8r+7:8r].
REQ-009 SHALL have port line_start  in  1  marks pix_col as first column of a new output line.
REQ-010 SHALL have ports sum1..sum5  out  8 each  signed saturated row sums, kernel rows 0..4, feeding writeback.
REQ-011 SHALL have port wb_en  out  1  one-cycle qualifier for sum1..sum5.
REQ-012 SHALL have port wgt_ready  out  1  high when all 25 weights are loaded.

Function
REQ-013 Weight FSM SHALL have states W_EMPTY, W_LOAD, W_READY; wgt_ready=1 only in W_READY.
REQ-014 In W_EMPTY/W_LOAD, wgt_load SHALL store wgt_in at index widx and increment widx; the 25th byte (widx=24) SHALL enter W_READY and set widx to 0.
REQ-015 wgt_load in W_READY SHALL store to index 0, set widx to 1, enter W_LOAD (reload); wgt_ready drops the next cycle.
REQ-016 pix_valid SHALL shift pix_col into a 5-column window (newest at column 4, oldest discarded).
REQ-017 Fill counter fcnt (0..5, saturating) SHALL increment on each pix_valid; pix_valid with line_start SHALL set fcnt=1; line_start without pix_valid SHALL set fcnt=0.
REQ-018 A window SHALL complete on an edge where pix_valid=1, post-update fcnt=5 and wgt_ready=1 at that edge.
REQ-019 Pipeline: edge N window complete; edge N+1 register 25 signed 16-bit products; edge N+2 register row sums; wb_en high for the cycle after edge N+2 only.
REQ-020 Row sum SHALL be the exact signed 19-bit sum of 5 products, arithmetic-shifted right by SHIFT, then saturated to [-128,127].
REQ-021 Back-to-back completing windows SHALL produce back-to-back wb_en pulses; no stall, no data loss.
REQ-022 Simultaneous wgt_load and pix_valid SHALL both be accepted; windows completing while not W_READY SHALL produce no wb_en.
REQ-023 Products in flight SHALL use the weights sampled at edge N, unaffected by a later reload.
REQ-024 sum1..sum5 SHALL hold their last values while wb_en=0.

Reset
REQ-025 rst low SHALL immediately clear FSM to W_EMPTY, widx, fcnt, window, weights, all pipeline registers and valid bits, sum1..sum5=0, wb_en=0, wgt_ready=0.
REQ-026 Reset mid-pipeline SHALL discard in-flight windows; no wb_en after rst releases until a new window completes.

Structure
REQ-027 Shared define header SHALL hold Byte width (8), KSIZE, weight count (25), and FSM state encodings.
REQ-028 A sub-module pe_row (5-tap signed MAC with 16-bit products, 19-bit sum, shift and saturate) SHALL be instantiated five times.
REQ-029 Weight storage, window, fcnt, FSM and valid pipeline SHALL live in pe_group.

Verification
REQ-030 SHIFT=0, 25 weights=1, 5 columns all pixels=2 -> one wb_en two cycles after 5th column, sum1..sum5=10.
REQ-031 SHIFT=7, weights=127, pixels=127 -> sums=127 (raw 80645>>7=630); weights=-128, pixels=127 -> sums=-128.
REQ-032 3 columns, then line_start column, then 3 more -> no wb_en; 5th column of new line -> wb_en.
REQ-033 Load 10 weights, stream 8 columns -> no wb_en; load remaining 15, next column -> wb_en with correct sums.
REQ-034 rst low one cycle after a completing edge -> wb_en never asserted, all outputs 0, wgt_ready=0.
REQ-035 10 consecutive columns after full load -> 6 consecutive wb_en pulses, each matching reference model.

Source files
------------

// File: rtl/pe_group_pkg.sv
// Shared widths, kernel geometry and weight-FSM encodings for the 5x5 PE group.
package pe_group_pkg;
   localparam int PE_BYTE_W = 8;
   localparam int PE_KSIZE  = 5;
   localparam int PE_NWGT   = PE_KSIZE * PE_KSIZE;

   typedef enum logic [1:0] {
      W_EMPTY = 2'd0,
      W_LOAD  = 2'd1,
      W_READY = 2'd2
   } w_state_t;
endpackage

// File: rtl/pe_group_row.sv
// One kernel row: five signed 8x8 products registered, then summed, shifted
// and saturated into a held 8-bit result.
module pe_row
   import pe_group_pkg::*;
#(
   parameter int SHIFT = 7
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 prod_en_i,
   input  logic                                 sum_en_i,
   input  logic [PE_KSIZE-1:0][PE_BYTE_W-1:0]   pix_i,
   input  logic [PE_KSIZE-1:0][PE_BYTE_W-1:0]   wgt_i,
   output logic [PE_BYTE_W-1:0]                 sum_o
);
   logic [PE_KSIZE-1:0][15:0] prod_d, prod_q;
   logic signed [18:0]        raw, shifted;
   logic [PE_BYTE_W-1:0]      sum_d, sum_q;

   always_comb begin
      raw = '0;
      for (int c = 0; c < PE_KSIZE; c++) begin
         logic signed [15:0] a, b;
         logic signed [18:0] p;
         a         = $signed(pix_i[c]);
         b         = $signed(wgt_i[c]);
         prod_d[c] = a * b;
         p         = $signed(prod_q[c]);
         raw       = raw + p;
      end
      shifted = raw >>> SHIFT;
      if (shifted > 19'sd127)       sum_d = 8'h7F;
      else if (shifted < -19'sd128) sum_d = 8'h80;
      else                          sum_d = shifted[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q <= '0;
         sum_q  <= '0;
      end else begin
         if (prod_en_i) prod_q <= prod_d;
         if (sum_en_i)  sum_q  <= sum_d;
      end
   end

   assign sum_o = sum_q;
endmodule

// File: rtl/pe_group.sv
// 5x5 convolution PE group: weight loader FSM, sliding pixel window, and a
// three-stage valid pipeline driving five pe_row MACs.
module pe_group
   import pe_group_pkg::*;
#(
   parameter int SHIFT = 7,
   parameter int KSIZE = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wgt_load,
   input  logic [PE_BYTE_W-1:0]            wgt_in,
   input  logic                            pix_valid,
   input  logic [PE_KSIZE*PE_BYTE_W-1:0]   pix_col,
   input  logic                            line_start,
   output logic [PE_BYTE_W-1:0]            sum1,
   output logic [PE_BYTE_W-1:0]            sum2,
   output logic [PE_BYTE_W-1:0]            sum3,
   output logic [PE_BYTE_W-1:0]            sum4,
   output logic [PE_BYTE_W-1:0]            sum5,
   output logic                            wb_en,
   output logic                            wgt_ready
);
   w_state_t                                state_q;
   logic [4:0]                              widx_q;
   logic [PE_NWGT-1:0][PE_BYTE_W-1:0]       wgt_q, wsnap_q;
   logic                                    wgt_ready_q;
   logic [PE_KSIZE-1:0][PE_KSIZE*PE_BYTE_W-1:0] win_q;
   logic [2:0]                              fcnt_d, fcnt_q;
   logic [2:0]                              vld_pipe_q;
   logic                                    complete;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= W_EMPTY;
         widx_q      <= '0;
         wgt_q       <= '0;
         wgt_ready_q <= 1'b0;
      end else if (wgt_load) begin
         case (state_q)
            W_READY: begin
               wgt_q[0]    <= wgt_in;
               widx_q      <= 5'd1;
               state_q     <= W_LOAD;
               wgt_ready_q <= 1'b0;
            end
            default: begin
               wgt_q[widx_q] <= wgt_in;
               if (widx_q == 5'(PE_NWGT - 1)) begin
                  widx_q      <= '0;
                  state_q     <= W_READY;
                  wgt_ready_q <= 1'b1;
               end else begin
                  widx_q  <= widx_q + 5'd1;
                  state_q <= W_LOAD;
               end
            end
         endcase
      end
   end

   always_comb begin
      fcnt_d = fcnt_q;
      if (pix_valid)       fcnt_d = line_start ? 3'd1 : ((fcnt_q == 3'd5) ? 3'd5 : fcnt_q + 3'd1);
      else if (line_start) fcnt_d = 3'd0;
   end

   assign complete = pix_valid && (fcnt_d == 3'd5) && wgt_ready_q;

   // Weights are snapshotted with the window so a reload right after a
   // completing edge cannot corrupt products still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fcnt_q     <= '0;
         win_q      <= '0;
         wsnap_q    <= '0;
         vld_pipe_q <= '0;
      end else begin
         fcnt_q     <= fcnt_d;
         vld_pipe_q <= {vld_pipe_q[1:0], complete};
         if (pix_valid) win_q   <= {pix_col, win_q[PE_KSIZE-1:1]};
         if (complete)  wsnap_q <= wgt_q;
      end
   end

   logic [PE_KSIZE-1:0][PE_KSIZE-1:0][PE_BYTE_W-1:0] row_pix, row_wgt;
   logic [PE_KSIZE-1:0][PE_BYTE_W-1:0]               row_sum;

   for (genvar r = 0; r < KSIZE; r++) begin : g_row
      for (genvar c = 0; c < KSIZE; c++) begin : g_tap
         assign row_pix[r][c] = win_q[c][PE_BYTE_W*r +: PE_BYTE_W];
         assign row_wgt[r][c] = wsnap_q[KSIZE*r + c];
      end
      pe_row #(.SHIFT(SHIFT)) u_row (
         .clk       (clk),
         .rst       (rst),
         .prod_en_i (vld_pipe_q[0]),
         .sum_en_i  (vld_pipe_q[1]),
         .pix_i     (row_pix[r]),
         .wgt_i     (row_wgt[r]),
         .sum_o     (row_sum[r])
      );
   end

   assign sum1      = row_sum[0];
   assign sum2      = row_sum[1];
   assign sum3      = row_sum[2];
   assign sum4      = row_sum[3];
   assign sum5      = row_sum[4];
   assign wb_en     = vld_pipe_q[2];
   assign wgt_ready = wgt_ready_q;
endmodule

// File: tb/tb_pe_group.sv
// Two PE groups (SHIFT=7 and SHIFT=0) share stimulus; a window-level model
// predicts every cycle's wb_en, sums and wgt_ready.
module tb_pe_group;
   logic clk = 1'b0;
   logic rst, wgt_load, pix_valid, line_start;
   logic [7:0]  wgt_in;
   logic [39:0] pix_col;
   logic [7:0]  a_s1, a_s2, a_s3, a_s4, a_s5, b_s1, b_s2, b_s3, b_s4, b_s5;
   logic        a_wb, a_rdy, b_wb, b_rdy;

   always #5 clk = ~clk;

   pe_group dut_a (
      .clk(clk), .rst(rst), .wgt_load(wgt_load), .wgt_in(wgt_in), .pix_valid(pix_valid),
      .pix_col(pix_col), .line_start(line_start), .sum1(a_s1), .sum2(a_s2), .sum3(a_s3),
      .sum4(a_s4), .sum5(a_s5), .wb_en(a_wb), .wgt_ready(a_rdy));

   pe_group #(.SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .wgt_load(wgt_load), .wgt_in(wgt_in), .pix_valid(pix_valid),
      .pix_col(pix_col), .line_start(line_start), .sum1(b_s1), .sum2(b_s2), .sum3(b_s3),
      .sum4(b_s4), .sum5(b_s5), .wb_en(b_wb), .wgt_ready(b_rdy));

   // ---- reference model: weights, window, fill count, pending results ----
   int mw [25];
   int win [5][5];   // [column][row], column 4 newest
   int mcnt, fc, cyc, n_vec, n_err;
   bit mrdy, ex_wb;
   int ex_s7 [5], ex_s0 [5];
   int q_due [$];
   int q_raw [$];

   function automatic int sat(int raw, int sh);
      int v;
      v = raw >>> sh;
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic model_reset();
      foreach (mw[i]) mw[i] = 0;
      foreach (win[c, r]) win[c][r] = 0;
      mcnt = 0; fc = 0; mrdy = 0; ex_wb = 0;
      for (int r = 0; r < 5; r++) begin ex_s7[r] = 0; ex_s0[r] = 0; end
      q_due.delete(); q_raw.delete();
   endtask

   task automatic model_edge(input logic wl, input logic [7:0] wi, input logic pv,
                             input logic [39:0] pc, input logic ls);
      int nfc;
      bit done;
      cyc++;
      nfc  = pv ? (ls ? 1 : (fc == 5 ? 5 : fc + 1)) : (ls ? 0 : fc);
      done = pv && nfc == 5 && mrdy;
      fc   = nfc;
      if (pv) begin
         for (int c = 0; c < 4; c++) win[c] = win[c+1];
         for (int r = 0; r < 5; r++) win[4][r] = $signed(pc[8*r +: 8]);
      end
      if (done) begin
         q_due.push_back(cyc + 2);
         for (int r = 0; r < 5; r++) begin
            int raw = 0;
            for (int c = 0; c < 5; c++) raw += mw[5*r + c] * win[c][r];
            q_raw.push_back(raw);
         end
      end
      if (wl) begin
         if (mrdy) begin mw[0] = $signed(wi); mcnt = 1; mrdy = 0; end
         else begin
            mw[mcnt] = $signed(wi); mcnt++;
            if (mcnt == 25) begin mcnt = 0; mrdy = 1; end
         end
      end
      ex_wb = 0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         void'(q_due.pop_front());
         ex_wb = 1;
         for (int r = 0; r < 5; r++) begin
            int raw = q_raw.pop_front();
            ex_s7[r] = sat(raw, 7);
            ex_s0[r] = sat(raw, 0);
         end
      end
   endtask

   function automatic logic [83:0] obs();
      return {a_rdy, a_wb, a_s1, a_s2, a_s3, a_s4, a_s5, b_rdy, b_wb, b_s1, b_s2, b_s3, b_s4, b_s5};
   endfunction

   function automatic logic [83:0] exp_vec();
      return {mrdy, ex_wb, 8'(ex_s7[0]), 8'(ex_s7[1]), 8'(ex_s7[2]), 8'(ex_s7[3]), 8'(ex_s7[4]),
              mrdy, ex_wb, 8'(ex_s0[0]), 8'(ex_s0[1]), 8'(ex_s0[2]), 8'(ex_s0[3]), 8'(ex_s0[4])};
   endfunction

   function automatic logic [39:0] col(input logic [7:0] b);
      return {5{b}};
   endfunction

   function automatic logic [39:0] rcol();
      return 40'({$urandom(), $urandom()});
   endfunction

   task automatic step(input logic wl, input logic [7:0] wi, input logic pv,
                       input logic [39:0] pc, input logic ls);
      @(negedge clk);
      wgt_load = wl; wgt_in = wi; pix_valid = pv; pix_col = pc; line_start = ls;
      @(posedge clk);
      model_edge(wl, wi, pv, pc, ls);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; wgt_load = 0; wgt_in = 0; pix_valid = 0; pix_col = 0; line_start = 0;
      model_reset();
      #3;
      n_vec++;
      if (obs() !== 84'd0) begin n_err++; $display("FAIL reset got=%h want=0", obs()); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (obs() !== exp_vec()) begin n_err++; $display("FAIL reset_release got=%h want=%h", obs(), exp_vec()); end
   endtask

   task automatic test_basic();
      int pulses = 0;
      for (int i = 0; i < 25; i++) begin
         step(1, 8'd1, 0, 0, 0);
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL basic_load cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      for (int i = 0; i < 7; i++) begin
         if (i < 5) step(0, 0, 1, col(8'd2), i == 0); else step(0, 0, 0, 0, 0);
         pulses += b_wb;
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL basic cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      n_vec++;
      if (!(b_wb === 1'b1 && pulses == 1 && {b_s1, b_s2, b_s3, b_s4, b_s5} === col(8'd10)
            && {a_s1, a_s2, a_s3, a_s4, a_s5} === 40'd0))
      begin n_err++; $display("FAIL basic_sum10 got=%h pulses=%0d want=0a0a0a0a0a pulses=1", {b_s1, b_s2, b_s3, b_s4, b_s5}, pulses); end
   endtask

   task automatic test_saturate();
      logic [7:0] wv [2];
      logic [7:0] want [2];
      wv[0] = 8'd127; wv[1] = 8'h80; want[0] = 8'h7F; want[1] = 8'h80;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) begin
            if (i < 25)      step(1, wv[k], 0, 0, 0);
            else if (i < 30) step(0, 0, 1, col(8'd127), i == 25);
            else             step(0, 0, 0, 0, 0);
            n_vec++;
            if (obs() !== exp_vec()) begin n_err++; $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
         end
         n_vec++;
         if ({a_wb, a_s1, a_s2, a_s3, a_s4, a_s5, b_wb, b_s1, b_s2, b_s3, b_s4, b_s5} !== {1'b1, col(want[k]), 1'b1, col(want[k])})
         begin n_err++; $display("FAIL saturate_%0d got=%h%h want=%h", k, {a_s1, a_s2, a_s3, a_s4, a_s5}, {b_s1, b_s2, b_s3, b_s4, b_s5}, col(want[k])); end
      end
   endtask

   task automatic test_line_start();
      int pulses = 0;
      for (int i = 0; i < 9; i++) begin
         if (i < 7) step(0, 0, 1, rcol(), i == 0 || i == 3); else step(0, 0, 0, 0, 0);
         pulses += a_wb;
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL line_start cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      for (int i = 0; i < 3; i++) begin
         if (i == 0) step(0, 0, 1, rcol(), 0); else step(0, 0, 0, 0, 0);
         pulses += a_wb;
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL line_start5 cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      n_vec++;
      if (pulses != 1) begin n_err++; $display("FAIL line_start_pulses got=%0d want=1", pulses); end
   endtask

   task automatic test_partial_load();
      int pulses = 0;
      for (int i = 0; i < 39; i++) begin
         if (i < 10)      step(1, 8'($urandom), 0, 0, 0);
         else if (i < 18) step(0, 0, 1, rcol(), i == 10);
         else if (i < 33) step(1, 8'($urandom), 0, 0, 0);
         else if (i < 34) step(0, 0, 1, rcol(), 0);
         else             step(0, 0, 0, 0, 0);
         if (i == 32) begin
            n_vec++;
            if (pulses != 0) begin n_err++; $display("FAIL partial_early got=%0d want=0", pulses); end
         end
         pulses += a_wb;
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL partial cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      n_vec++;
      if (pulses != 1) begin n_err++; $display("FAIL partial_pulses got=%0d want=1", pulses); end
   endtask

   task automatic test_reset_midpipe();
      int pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) step(0, 0, 1, rcol(), i == 0); else step(0, 0, 0, 0, 0);
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL midpipe cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      #2 rst = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (obs() !== 84'd0) begin n_err++; $display("FAIL midpipe_reset got=%h want=0", obs()); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0);
         pulses += a_wb + b_wb;
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL midpipe_after cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      n_vec++;
      if (pulses != 0 || a_rdy !== 1'b0) begin n_err++; $display("FAIL midpipe_pulses got=%0d rdy=%b want=0 0", pulses, a_rdy); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      for (int i = 0; i < 38; i++) begin
         if (i < 25)      step(1, 8'($urandom), 0, 0, 0);
         else if (i < 35) step(0, 0, 1, rcol(), i == 25);
         else             step(0, 0, 0, 0, 0);
         pulses += a_wb;
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
      n_vec++;
      if (pulses != 6) begin n_err++; $display("FAIL b2b_pulses got=%0d want=6", pulses); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 7) == 0), 8'($urandom), $urandom_range(0, 1) == 1,
              rcol(), ($urandom_range(0, 9) == 0));
         n_vec++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), exp_vec()); end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      test_reset();
      test_basic();
      test_saturate();
      test_line_start();
      test_partial_load();
      test_reset_midpipe();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
